// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Optional feature macro: ADDER_SAT_EN (adds the per-beat saturation request bit).
package adder_pkg;

  // Operation encoding on in_sub.
  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  // Sideband that travels with each beat through the slices. The carry field
  // is the carry into the next slice (or out of the MSB once the beat reaches
  // the last stage).
  typedef struct packed {
    logic sub;
`ifdef ADDER_SAT_EN
    logic sat;
`endif
    logic carry;
    logic a_sign;
    logic b_sign;
  } side_t;

  // Width of one carry-chain slice.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered S-bit slice of the carry chain: slice add, carry register,
// stage valid bit and the advance (stall) decision for that stage.
module adder_slice
  import adder_pkg::*;
#(
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         next_advance,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  side_t        side_in,
  output logic         valid,
  output logic         advance,
  output logic [S-1:0] sum,
  output side_t        side_out
);

  logic [S:0] total;
  side_t      side_next;

  // Subtract inverts B in every slice; the +1 enters as slice 0's carry-in.
  always_comb begin
    total           = {1'b0, a} + {1'b0, b ^ {S{side_in.sub}}} + {{S{1'b0}}, side_in.carry};
    side_next       = side_in;
    side_next.carry = total[S];
  end

  // A stage moves when it is empty or when its contents move on downstream.
  assign advance = !valid || next_advance;

  // Stage registers load only when the stage advances, so a stalled beat holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      sum      <= '0;
      side_out <= '0;
    end else if (advance) begin
      valid    <= in_valid;
      sum      <= total[S-1:0];
      side_out <= side_next;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry/overflow/zero flags and valid/ready on
// both sides. The carry chain is cut into STAGES registered slices; upper
// operand slices ride along in skew registers and finished lower result
// slices ride along in deskew registers.
// Optional feature macro: ADDER_SAT_EN (in_sat port and signed clamp).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
`ifdef ADDER_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int S = slice_width(WIDTH, STAGES);

  logic [WIDTH-1:0] raw_result;
  side_t            last_side;
  logic             ovf;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand slices gi..STAGES-1 presented to this stage.
      logic [(STAGES-gi)*S-1:0] a_src;
      logic [(STAGES-gi)*S-1:0] b_src;
      side_t                    side_src;
      logic                     valid_src;
      logic                     next_adv;
      logic                     adv;
      logic                     vld;
      logic [S-1:0]             sum;
      side_t                    side_q;
      // Result slices 0..gi as held by this stage.
      logic [(gi+1)*S-1:0]      res_out;

      if (gi == 0) begin : g_head
        // Build the sideband for a new beat; slice 0 carry-in is the subtract bit.
        always_comb begin
          side_src        = '0;
          side_src.sub    = (in_sub == SUB_OP);
          side_src.carry  = (in_sub == SUB_OP);
          side_src.a_sign = in_a[WIDTH-1];
          side_src.b_sign = in_b[WIDTH-1];
`ifdef ADDER_SAT_EN
          side_src.sat    = in_sat;
`endif
        end
        assign a_src     = in_a;
        assign b_src     = in_b;
        assign valid_src = in_valid;
        assign res_out   = sum;
      end else begin : g_body
        logic [gi*S-1:0] lo_reg;

        assign a_src     = g_stage[gi-1].g_fwd.a_skew;
        assign b_src     = g_stage[gi-1].g_fwd.b_skew;
        assign side_src  = g_stage[gi-1].side_q;
        assign valid_src = g_stage[gi-1].vld;

        // Deskew: carry the already-finished lower result slices forward.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            lo_reg <= '0;
          end else if (adv) begin
            lo_reg <= g_stage[gi-1].res_out;
          end
        end

        assign res_out = {sum, lo_reg};
      end

      if (gi < STAGES-1) begin : g_fwd
        logic [(STAGES-gi-1)*S-1:0] a_skew;
        logic [(STAGES-gi-1)*S-1:0] b_skew;

        // Skew: hand the not-yet-added operand slices to the next stage.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            a_skew <= '0;
            b_skew <= '0;
          end else if (adv) begin
            a_skew <= a_src[(STAGES-gi)*S-1:S];
            b_skew <= b_src[(STAGES-gi)*S-1:S];
          end
        end

        assign next_adv = g_stage[gi+1].adv;
      end else begin : g_tail
        assign next_adv = out_ready;
      end

      adder_slice #(
        .S(S)
      ) u_slice (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (valid_src),
        .next_advance(next_adv),
        .a           (a_src[S-1:0]),
        .b           (b_src[S-1:0]),
        .side_in     (side_src),
        .valid       (vld),
        .advance     (adv),
        .sum         (sum),
        .side_out    (side_q)
      );
    end
  endgenerate

  assign raw_result = g_stage[STAGES-1].res_out;
  assign last_side  = g_stage[STAGES-1].side_q;
  assign out_valid  = g_stage[STAGES-1].vld;
  assign in_ready   = g_stage[0].adv;

  // Flags from the last stage; overflow compares against the effective B sign.
  always_comb begin
    ovf = (last_side.a_sign == (last_side.b_sign ^ last_side.sub)) &&
          (raw_result[WIDTH-1] != last_side.a_sign);
    out_result = raw_result;
`ifdef ADDER_SAT_EN
    if (last_side.sat && ovf) begin
      out_result = last_side.a_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    out_carry    = last_side.carry;
    out_overflow = ovf;
    // Qualified by valid so the idle/reset value is 0 rather than "result is zero".
    out_zero     = out_valid && (out_result == '0);
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4). Honours ADDER_SAT_EN.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef ADDER_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_overflow;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sub      (in_sub),
`ifdef ADDER_SAT_EN
    .in_sat      (in_sat),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_carry   (out_carry),
    .out_overflow(out_overflow),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vtab[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input logic sat, input logic [31:0] res, input logic carry,
                              input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.sat = sat;
    v.res = res; v.carry = carry; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  // Plain 33-bit reference for the streaming test.
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
    return t[31:0];
  endfunction

  // Single beat with out_ready held high: accept, time the emit edge, check fields.
  task automatic run_vec(input vec_t v, input string tag);
    int k;
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_sat = v.sat; in_valid = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    chk({tag, " latency"}, k, STAGES);
    chk({tag, " result"}, out_result, v.res);
    chk({tag, " carry"}, {31'd0, out_carry}, {31'd0, v.carry});
    chk({tag, " overflow"}, {31'd0, out_overflow}, {31'd0, v.ovf});
    chk({tag, " zero"}, {31'd0, out_zero}, {31'd0, v.zero});
    $display("beat %s: a=%h b=%h sub=%0d sat=%0d -> res=%h c=%0d v=%0d z=%0d lat=%0d",
             tag, v.a, v.b, v.sub, v.sat, out_result, out_carry, out_overflow, out_zero, k);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sa [16];
    logic [31:0] sb [16];
    logic        ssub [16];
    int          sent;
    int          recv;
    int          cyc;
    logic        hold;
    logic        acc;
    logic [34:0] held;

    vtab[0]  = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    vtab[1]  = mk(32'd5,         32'd5,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    vtab[2]  = mk(32'd3,         32'd5,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    vtab[3]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    vtab[4]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    vtab[5]  = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    vtab[6]  = mk(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0);
    vtab[7]  = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    vtab[8]  = mk(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    vtab[9]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    vtab[10] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
                  SAT_ON ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    vtab[11] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
                  SAT_ON ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    vtab[12] = mk(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0;
    out_ready = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_carry", {31'd0, out_carry}, 32'd0);
    chk("reset out_overflow", {31'd0, out_overflow}, 32'd0);
    chk("reset out_zero", {31'd0, out_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_vec(vtab[i], $sformatf("v%0d", i));
    end

    // Stream 16 beats with random backpressure.
    for (int i = 0; i < 16; i++) begin
      sa[i]   = 32'h0123_4567 * i;
      sb[i]   = 32'hFFFF_FFF0 + i;
      ssub[i] = i[0];
    end
    sent = 0; recv = 0; cyc = 0; hold = 1'b0; held = '0;
    while ((recv < 16) && (cyc < 400)) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 16);
      if (sent < 16) begin
        in_a = sa[sent]; in_b = sb[sent]; in_sub = ssub[sent]; in_sat = 1'b0;
      end
      @(negedge clk);
      if (hold) begin
        chk("stall valid held", {31'd0, out_valid}, 32'd1);
        chk("stall outputs stable", {out_result, out_carry, out_overflow, out_zero},
            held);
      end
      hold = out_valid && !out_ready;
      held = {out_result, out_carry, out_overflow, out_zero};
      if (out_valid && out_ready) begin
        if (recv < 16) begin
          chk($sformatf("stream beat %0d", recv), out_result,
              ref_res(sa[recv], sb[recv], ssub[recv]));
          $display("stream beat %0d: res=%h", recv, out_result);
        end
        recv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    chk("stream beats sent", sent, 16);
    chk("stream beats received", recv, 16);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 1) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stream no extra beat", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Fill the pipeline while stalled, then release with a new beat waiting.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = i + 1; in_b = 32'd10; in_sub = 1'b0; in_sat = 1'b0;
      @(negedge clk);
      chk($sformatf("fill accept %0d", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd10;
    @(negedge clk);
    chk("full stalled in_ready", {31'd0, in_ready}, 32'd0);
    chk("full stalled out_valid", {31'd0, out_valid}, 32'd1);
    chk("full stalled head", out_result, 32'd11);
    #1;
    out_ready = 1'b1;
    #1;
    chk("full released in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk($sformatf("drain %0d valid", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("drain %0d result", j), out_result, 32'd11 + j);
      $display("drain beat %0d: res=%h", j, out_result);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'd100 + i; in_b = 32'd0; in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid reset out_result", out_result, 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(32'h0000_0042, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0043, 1'b0, 1'b0, 1'b0),
            "post-reset");
    @(negedge clk);
    chk("post-reset no stale beat", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
